// File: rtl/multicycle_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: FSM states, instruction
// classes, opcode patterns and ALU operation codes.
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_LDUR = 3'd2,
    CLS_STUR = 3'd3,
    CLS_CBZ  = 3'd4,
    CLS_B    = 3'd5,
    CLS_ILL  = 3'd6
  } class_e;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  // CBZ and B are identified by their upper bits only; the rest is immediate.
  localparam logic [7:0] OP_CBZ_HI = 8'hB4;
  localparam logic [5:0] OP_B_HI   = 6'h05;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_PASSB = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode-to-class decode, shared by the sequencer and the ALU control.
module opcode_classifier
  import multicycle_pkg::*;
(
  input  logic [10:0] opcode,
  output class_e      op_class
);

  always_comb begin
    op_class = CLS_ILL;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
      op_class = CLS_R;
    end else if (opcode == OP_LDUR) begin
      op_class = CLS_LDUR;
    end else if (opcode == OP_STUR) begin
      op_class = CLS_STUR;
    end else if (opcode[10:3] == OP_CBZ_HI) begin
      op_class = CLS_CBZ;
    end else if (opcode[10:5] == OP_B_HI) begin
      op_class = CLS_B;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: steps each instruction through FETCH/DECODE/EXEC/
// MEM/WB/BRANCH with ready handshakes, drives datapath strobes, counts retirements.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [10:0]      opcode,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             mdr_write,
  output logic             reg_write,
  output logic             reg2loc,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  class_e           dec_class;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    illegal_d  = illegal_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    mdr_write  = 1'b0;
    reg_write  = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALU_ADD;
    pc_write   = 1'b0;
    pc_src     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req = run;
        if (run && imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        class_d = dec_class;
        reg2loc = (dec_class == CLS_STUR) || (dec_class == CLS_CBZ);
        case (dec_class)
          CLS_R, CLS_LDUR, CLS_STUR: state_d = ST_EXEC;
          CLS_CBZ, CLS_B:            state_d = ST_BRANCH;
          default: begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end

      ST_EXEC: begin
        if (class_q == CLS_R) begin
          alu_op  = ALU_FUNCT;
          alu_src = 1'b0;
          state_d = ST_WB;
        end else if (class_q == CLS_LDUR || class_q == CLS_STUR) begin
          alu_op  = ALU_ADD;
          alu_src = 1'b1;
          reg2loc = (class_q == CLS_STUR);
          state_d = ST_MEM;
        end else begin
          state_d = ST_FETCH;
        end
      end

      // Address stays on the ALU while the data memory is allowed to stall.
      ST_MEM: begin
        dmem_read  = (class_q == CLS_LDUR);
        dmem_write = (class_q == CLS_STUR);
        alu_src    = 1'b1;
        alu_op     = ALU_ADD;
        if (dmem_ready) begin
          if (class_q == CLS_LDUR) begin
            mdr_write = 1'b1;
            state_d   = ST_WB;
          end else if (class_q == CLS_STUR) begin
            pc_write = 1'b1;
            pc_src   = 1'b0;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == CLS_LDUR);
        pc_write   = 1'b1;
        pc_src     = 1'b0;
        state_d    = ST_FETCH;
      end

      ST_BRANCH: begin
        pc_write = 1'b1;
        if (class_q == CLS_CBZ) begin
          reg2loc = 1'b1;
          alu_op  = ALU_PASSB;
          pc_src  = alu_zero;
        end else if (class_q == CLS_B) begin
          pc_src = 1'b1;
        end
        state_d = ST_FETCH;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Strobes must be quiet for the whole reset pulse, not just after the first edge.
    if (reset) begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      mdr_write  = 1'b0;
      reg_write  = 1'b0;
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = ALU_ADD;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (pc_write) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      class_q   <= CLS_NONE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
